// File: rtl/fir_ctrl_pkg.sv
// Shared types for the FIR sequencing controller: datapath opcodes,
// register-file index map and controller state encoding.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        COPY  = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        ADD   = 3'd4,
        SUB   = 3'd5,
        MUL   = 3'd6
    } op_t;

    // R1 holds the newest sample; coefficients sit directly above the sample line.
    localparam int R_RESULT = 0;
    localparam int R_S1     = 1;
    localparam int R_S2     = 2;
    localparam int R_S3     = 3;
    localparam int R_S4     = 4;
    localparam int R_F0     = 5;
    localparam int R_F1     = 6;
    localparam int R_F2     = 7;
    localparam int R_F3     = 8;
    localparam int R_NEW    = 9;
    localparam int R_TMP    = 10;

    typedef enum logic [4:0] {
        S_IDLE,
        S_STORE,
        S_SH1,
        S_SH2,
        S_SH3,
        S_SH4,
        S_MUL1,
        S_CPY,
        S_MUL2,
        S_SUB1,
        S_MUL3,
        S_ADD1,
        S_MUL4,
        S_SUB2,
        S_EIDLE,
        S_LD_C0,
        S_WT_C1,
        S_LD_C1,
        S_WT_C2,
        S_LD_C2,
        S_WT_C3,
        S_LD_C3
    } state_t;

endpackage

// File: rtl/fir_sample_controller.sv
// Sequencing FSM of the FIR core: turns dr/lc strobes into a register-file
// opcode stream, sample-counter pulses and the busy/error handshake.
module fir_sample_controller
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS  = 4,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 dr,
    input  logic                 lc,
    input  logic                 overflow,
    output logic                 cnt_up,
    output logic                 clear,
    output logic                 modwait,
    output logic [2:0]           op,
    output logic [REG_IDX_W-1:0] src1,
    output logic [REG_IDX_W-1:0] src2,
    output logic [REG_IDX_W-1:0] dest,
    output logic                 err
);

    localparam int LAST_COEF = R_F0 + NUM_TAPS - 1;

    state_t state;
    state_t next_state;
    op_t    op_c;

    function automatic logic [REG_IDX_W-1:0] ridx(input int r);
        return REG_IDX_W'(r);
    endfunction

    // WT states and the two idle states leave the slave free to talk to us.
    function automatic logic is_busy(input state_t s);
        case (s)
            S_IDLE, S_EIDLE, S_WT_C1, S_WT_C2, S_WT_C3: return 1'b0;
            default:                                    return 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            modwait <= 1'b0;
        end else begin
            state   <= next_state;
            modwait <= is_busy(next_state);
        end
    end

    always_comb begin
        next_state = state;
        op_c       = NOP;
        src1       = '0;
        src2       = '0;
        dest       = '0;
        cnt_up     = 1'b0;
        clear      = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE, S_EIDLE: begin
                err = (state == S_EIDLE);
                if (dr)      next_state = S_STORE;
                else if (lc) next_state = S_LD_C0;
            end
            S_STORE: begin
                op_c       = LOAD1;
                dest       = ridx(R_NEW);
                next_state = dr ? S_SH1 : S_EIDLE;
            end
            S_SH1: begin
                op_c = COPY; src1 = ridx(R_S3); dest = ridx(R_S4);
                cnt_up     = 1'b1;
                next_state = S_SH2;
            end
            S_SH2: begin
                op_c = COPY; src1 = ridx(R_S2); dest = ridx(R_S3);
                next_state = S_SH3;
            end
            S_SH3: begin
                op_c = COPY; src1 = ridx(R_S1); dest = ridx(R_S2);
                next_state = S_SH4;
            end
            S_SH4: begin
                op_c = COPY; src1 = ridx(R_NEW); dest = ridx(R_S1);
                next_state = S_MUL1;
            end
            S_MUL1: begin
                op_c = MUL; src1 = ridx(R_S1); src2 = ridx(R_F0); dest = ridx(R_TMP);
                next_state = S_CPY;
            end
            S_CPY: begin
                op_c = COPY; src1 = ridx(R_TMP); dest = ridx(R_RESULT);
                next_state = S_MUL2;
            end
            S_MUL2: begin
                op_c = MUL; src1 = ridx(R_S2); src2 = ridx(R_F1); dest = ridx(R_TMP);
                next_state = S_SUB1;
            end
            S_SUB1: begin
                op_c = SUB; src1 = ridx(R_RESULT); src2 = ridx(R_TMP); dest = ridx(R_RESULT);
                next_state = overflow ? S_EIDLE : S_MUL3;
            end
            S_MUL3: begin
                op_c = MUL; src1 = ridx(R_S3); src2 = ridx(R_F2); dest = ridx(R_TMP);
                next_state = S_ADD1;
            end
            S_ADD1: begin
                op_c = ADD; src1 = ridx(R_RESULT); src2 = ridx(R_TMP); dest = ridx(R_RESULT);
                next_state = overflow ? S_EIDLE : S_MUL4;
            end
            S_MUL4: begin
                op_c = MUL; src1 = ridx(R_S4); src2 = ridx(R_F3); dest = ridx(R_TMP);
                next_state = S_SUB2;
            end
            S_SUB2: begin
                op_c = SUB; src1 = ridx(R_RESULT); src2 = ridx(R_TMP); dest = ridx(R_RESULT);
                next_state = overflow ? S_EIDLE : S_IDLE;
            end
            // Coefficient reload restarts the sample count from zero.
            S_LD_C0: begin
                op_c = LOAD2; dest = ridx(R_F0); clear = 1'b1;
                next_state = S_WT_C1;
            end
            S_WT_C1: if (lc) next_state = S_LD_C1;
            S_LD_C1: begin
                op_c = LOAD2; dest = ridx(R_F1);
                next_state = S_WT_C2;
            end
            S_WT_C2: if (lc) next_state = S_LD_C2;
            S_LD_C2: begin
                op_c = LOAD2; dest = ridx(R_F2);
                next_state = S_WT_C3;
            end
            S_WT_C3: if (lc) next_state = S_LD_C3;
            S_LD_C3: begin
                op_c = LOAD2; dest = ridx(LAST_COEF);
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign op = op_c;

endmodule

// File: tb/tb_fir_sample_controller.sv
// Randomized directed bench for fir_sample_controller; every cycle's outputs
// are compared against a program-table model of the sequencing rules.
module tb_fir_sample_controller;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dr;
    logic       lc;
    logic       overflow;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cnt_pulses = 0;
    int clr_pulses = 0;
    bit err_exp = 1'b0;

    fir_sample_controller #(.NUM_TAPS(4), .REG_IDX_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
        .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
        .src1(src1), .src2(src2), .dest(dest), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_up) cnt_pulses++;
        if (clear)  clr_pulses++;
    end

    // Sample program: one row per busy cycle, {op, src1, src2, dest}.
    localparam int NSTEP = 13;
    logic [2:0] p_op [NSTEP] = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6, 3'd1, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [3:0] p_s1 [NSTEP] = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd9, 4'd1, 4'd10, 4'd2, 4'd0, 4'd3, 4'd0, 4'd4, 4'd0};
    logic [3:0] p_s2 [NSTEP] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd6, 4'd10, 4'd7, 4'd10, 4'd8, 4'd10};
    logic [3:0] p_d  [NSTEP] = '{4'd9, 4'd4, 4'd3, 4'd2, 4'd1, 4'd10, 4'd0, 4'd10, 4'd0, 4'd10, 4'd0, 4'd10, 4'd0};

    logic [18:0] obs;
    assign obs = {op, src1, src2, dest, cnt_up, clear, modwait, err};

    function automatic logic [18:0] vec(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] d, input logic c, input logic cl,
                                        input logic mw, input logic e);
        return {o, a, b, d, c, cl, mw, e};
    endfunction

    task automatic check(input string tag, input logic [18:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick(input string tag, input logic [18:0] expv);
        @(negedge clk);
        check(tag, expv);
    endtask

    task automatic idle_cycles(input int n);
        dr = 1'b0; lc = 1'b0; overflow = 1'b0;
        for (int i = 0; i < n; i++) tick("idle", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, err_exp));
    endtask

    // Starts just after a checked idle cycle; ends just after the next checked idle cycle.
    task automatic load_coefs(input int gap, input bit noise);
        dr = 1'b0; lc = 1'b1; overflow = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick($sformatf("ld_c%0d", k), vec(3'd3, 4'd0, 4'd0, 4'(5 + k), 1'b0, k == 0, 1'b1, 1'b0));
            lc = 1'b0;
            dr = (k == 3) ? 1'b0 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick($sformatf("wt_c%0d", k + 1), vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    dr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    lc = (g == gap - 1);
                end
            end
        end
        err_exp = 1'b0;
        tick("ld_done", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // ovf_step selects the ADD/SUB row (8, 10 or 12) that reports overflow; -1 for none.
    task automatic run_sample(input bit abort, input int ovf_step, input bit lc_too);
        dr = 1'b1; lc = lc_too; overflow = 1'b0;
        for (int k = 0; k < NSTEP; k++) begin
            tick($sformatf("step%0d", k), vec(p_op[k], p_s1[k], p_s2[k], p_d[k], k == 1, 1'b0, 1'b1, 1'b0));
            lc = 1'b0;
            if (k == 0 && abort) dr = 1'b0;
            if (k == 1) dr = 1'b0;
            if (k == 0 && abort) break;
            if (k == ovf_step) begin
                overflow = 1'b1;
                break;
            end
        end
        if (abort || ovf_step >= 0) begin
            err_exp = 1'b1;
            tick("eidle", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            overflow = 1'b0;
        end else begin
            err_exp = 1'b0;
            tick("done", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        int c0;
        int k0;
        int r;
        int steps[3] = '{8, 10, 12};

        // Reset held with both strobes high.
        n_rst = 1'b0; dr = 1'b1; lc = 1'b1; overflow = 1'b0;
        for (int i = 0; i < 3; i++) tick("reset", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        dr = 1'b0; lc = 1'b0; n_rst = 1'b1;
        tick("post_reset", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        load_coefs(5, 1'b0);
        run_sample(1'b0, -1, 1'b0);
        run_sample(1'b1, -1, 1'b0);
        idle_cycles(2);
        run_sample(1'b0, -1, 1'b0);
        run_sample(1'b0, 10, 1'b0);
        idle_cycles(2);
        load_coefs(2, 1'b1);
        run_sample(1'b0, 12, 1'b0);
        run_sample(1'b0, 8, 1'b0);
        load_coefs(1, 1'b1);

        // Asynchronous reset in the middle of a sample.
        dr = 1'b1;
        tick("pre_rst_store", vec(3'd2, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0));
        tick("pre_rst_sh1", vec(3'd1, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0));
        dr = 1'b0;
        #2 n_rst = 1'b0;
        #1 check("async_rst", vec(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        n_rst = 1'b1;
        err_exp = 1'b0;
        idle_cycles(1);

        // Randomized mix of transactions.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       load_coefs($urandom_range(1, 6), 1'b1);
            else if (r == 2) run_sample(1'b1, -1, 1'b0);
            else if (r < 5)  run_sample(1'b0, steps[$urandom_range(0, 2)], 1'b0);
            else             run_sample(1'b0, -1, err_exp ? 1'b0 : 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 3));
        end

        // dr and lc together take the sample path, then a long run of samples.
        if (err_exp) run_sample(1'b0, -1, 1'b0);
        c0 = cnt_pulses;
        k0 = clr_pulses;
        run_sample(1'b0, -1, 1'b1);
        for (int i = 1; i < 1000; i++) run_sample(1'b0, -1, 1'b0);
        total++;
        assert (cnt_pulses - c0 === 1000) else begin
            bad++;
            $error("FAIL cnt_up_1000 observed=%0d expected=%0d", cnt_pulses - c0, 1000);
        end
        total++;
        assert (clr_pulses - k0 === 0) else begin
            bad++;
            $error("FAIL no_clear observed=%0d expected=%0d", clr_pulses - k0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
